// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared constants for the instruction-memory loader:
//   - FSM state encoding (plain localparams so older tools can consume them)
//   - err_code values reported on the loader's err_code port
//   - default frame start marker
package imem_loader_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CNT_LO = 3'd1;
    localparam logic [2:0] ST_CNT_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CSUM   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd6;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_OVF     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// imem_loader_word_assembler
// Packs a byte stream into little-endian 32-bit words (first byte -> bits 7:0).
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   clear           restart at byte 0 of a word (start of a new frame)
//   byte_en         byte_in is taken this cycle
//   byte_in         incoming byte
//   word            assembled word (stable while word_valid is high)
//   word_valid      one-cycle pulse in the cycle after the 4th byte is taken
//   word_last       combinational: the byte taken this cycle completes a word
module imem_loader_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        word_last
);

    logic [1:0]  idx;
    logic [31:0] sr;

    assign word_last = byte_en && (idx == 2'd3);
    assign word      = sr;

    // Shifting right puts the first byte of a word into bits 7:0 after four bytes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx        <= 2'd0;
            sr         <= 32'd0;
            word_valid <= 1'b0;
        end else if (clear) begin
            idx        <= 2'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= word_last;
            if (byte_en) begin
                sr  <= {byte_in, sr[31:8]};
                idx <= idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Loads a framed program image into instruction memory and holds the core
// stopped until a frame with a correct XOR checksum has been written.
// Frame: SYNC_BYTE, COUNT_LO, COUNT_HI, 4*N payload bytes (LSB first), CSUM.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   rx_data/valid/ready   byte stream; ready is always 1 (loader never stalls)
//   imem_we/addr/wdata    one-cycle word write to instruction memory
//   cpu_run               1 releases the core
//   done                  last frame loaded successfully
//   err_code              0 none, 1 checksum, 2 overflow, 3 timeout
//   dbg_state             current FSM state (imem_loader_pkg encoding)
// Build option: define LOADER_TIMEOUT_EN to enable the inter-byte timeout
// (TIMEOUT_CYC clk cycles without an accepted byte mid-frame -> err_code 3).
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W      = 8,
    parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE,
    parameter int         TIMEOUT_CYC = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_run,
    output logic              done,
    output logic [1:0]        err_code,
    output logic [2:0]        dbg_state
);

    // Valid/ready: a byte transfers on a rising edge where rx_valid && rx_ready.
    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    logic [2:0]  state;
    logic [7:0]  cnt_lo;
    logic [15:0] cnt;
    logic [16:0] widx;
    logic [7:0]  csum;
    logic        accept;
    logic        start;
    logic        data_byte;
    logic        word_last;
    logic        timeout;
    logic [16:0] n_hdr;

    assign rx_ready  = 1'b1;
    assign accept    = rx_valid && rx_ready;
    assign start     = accept && (rx_data == SYNC_BYTE) &&
                       (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign data_byte = accept && (state == ST_DATA);
    assign n_hdr     = {1'b0, rx_data, cnt_lo};
    assign dbg_state = state;

    imem_loader_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (start),
        .byte_en    (data_byte),
        .byte_in    (rx_data),
        .word       (imem_wdata),
        .word_valid (imem_we),
        .word_last  (word_last)
    );

`ifdef LOADER_TIMEOUT_EN
    logic [31:0] tcnt;
    logic        active;

    assign active  = (state == ST_CNT_LO) || (state == ST_CNT_HI) ||
                     (state == ST_DATA)   || (state == ST_CSUM);
    // An accepted byte in the expiry cycle wins over the timeout.
    assign timeout = active && !accept && (tcnt == 32'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt <= 32'd0;
        end else if (accept || !active) begin
            tcnt <= 32'd0;
        end else begin
            tcnt <= tcnt + 32'd1;
        end
    end
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt_lo    <= 8'd0;
            cnt       <= 16'd0;
            widx      <= 17'd0;
            csum      <= 8'd0;
            imem_addr <= '0;
            cpu_run   <= 1'b0;
            done      <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            if (start) begin
                state    <= ST_CNT_LO;
                cpu_run  <= 1'b0;
                done     <= 1'b0;
                err_code <= ERR_NONE;
                csum     <= 8'd0;
                widx     <= 17'd0;
            end
            case (state)
                ST_CNT_LO: if (accept) begin
                    cnt_lo <= rx_data;
                    state  <= ST_CNT_HI;
                end
                ST_CNT_HI: if (accept) begin
                    cnt <= {rx_data, cnt_lo};
                    if (n_hdr > DEPTH) begin
                        state    <= ST_ERR;
                        err_code <= ERR_OVF;
                    end else if (n_hdr == 17'd0) begin
                        state <= ST_CSUM;
                    end else begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: if (accept) begin
                    csum <= csum ^ rx_data;
                    // Address is latched now so it lines up with the write pulse next cycle.
                    if (word_last) begin
                        imem_addr <= widx[ADDR_W-1:0];
                        widx      <= widx + 17'd1;
                        if (widx + 17'd1 == {1'b0, cnt}) begin
                            state <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: if (accept) begin
                    if (rx_data == csum) begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        cpu_run <= 1'b1;
                    end else begin
                        state    <= ST_ERR;
                        err_code <= ERR_CSUM;
                    end
                end
                ST_IDLE, ST_DONE, ST_ERR: ;
                default: state <= ST_IDLE;
            endcase
            if (timeout) begin
                state    <= ST_ERR;
                err_code <= ERR_TIMEOUT;
            end
        end
    end

endmodule
